// File: rtl/rv_mc_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle controller: FSM states, opcodes, ALU codes and mux selects.
// The optional illegal-instruction trap is enabled by defining RV_ILLEGAL_TRAP_EN.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_REL   = 2'd1,
        PC_JALR  = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_src_t;

    // Instruction class as seen by the sequencer; CLS_ILL covers any unrecognised encoding.
    typedef enum logic [3:0] {
        CLS_ALU    = 4'd0,
        CLS_LUI    = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_JALR   = 4'd7,
        CLS_NOP    = 4'd8,
        CLS_ILL    = 4'd9
    } cls_t;

    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_t alu_for_branch(input logic [2:0] f3);
        case (f3[2:1])
            2'b10:   return ALU_SLT;
            2'b11:   return ALU_SLTU;
            default: return ALU_SUB;
        endcase
    endfunction

endpackage

// File: rtl/rv_mc_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the sequencer, slave is the datapath side.
interface rv_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             br_taken;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic [3:0]       alu_op;
    logic             alu_a_src;
    logic             alu_b_src;
    logic [2:0]       imm_sel;
    logic             dmem_req;
    logic             dmem_we;
    logic [1:0]       dmem_size;
    logic             rf_we;
    logic [1:0]       wb_src;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic             illegal;

    modport master (
        input  instr, br_taken, imem_ready, dmem_ready,
        output imem_req, ir_we, pc_we, pc_src, alu_op, alu_a_src, alu_b_src, imm_sel,
               dmem_req, dmem_we, dmem_size, rf_we, wb_src, retire, instret, illegal
    );

    modport slave (
        output instr, br_taken, imem_ready, dmem_ready,
        input  imem_req, ir_we, pc_we, pc_src, alu_op, alu_a_src, alu_b_src, imm_sel,
               dmem_req, dmem_we, dmem_size, rf_we, wb_src, retire, instret, illegal
    );
endinterface

// File: rtl/rv_mc_ctrl_alu_dec.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU op, immediate format, operand selects and class.
module rv_alu_dec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output alu_op_t    o_alu_op,
    output imm_sel_t   o_imm_sel,
    output logic       o_a_src,
    output logic       o_b_src,
    output cls_t       o_cls
);

    always_comb begin
        o_alu_op  = ALU_ADD;
        o_imm_sel = IMM_I;
        o_a_src   = 1'b0;
        o_b_src   = 1'b0;
        o_cls     = CLS_ILL;
        // Full 7-bit compare, so any encoding with instr[1:0] != 2'b11 lands in default.
        case (i_opcode)
            OPC_OP: begin
                o_alu_op = alu_from_f3(i_funct3, i_funct7_5);
                o_cls    = CLS_ALU;
            end
            OPC_OPIMM: begin
                o_alu_op = alu_from_f3(i_funct3, i_funct7_5 & (i_funct3 == 3'b101));
                o_b_src  = 1'b1;
                o_cls    = CLS_ALU;
            end
            OPC_LUI: begin
                o_alu_op  = ALU_PASSB;
                o_imm_sel = IMM_U;
                o_b_src   = 1'b1;
                o_cls     = CLS_LUI;
            end
            OPC_AUIPC: begin
                o_imm_sel = IMM_U;
                o_a_src   = 1'b1;
                o_b_src   = 1'b1;
                o_cls     = CLS_AUIPC;
            end
            OPC_LOAD: begin
                o_b_src = 1'b1;
                o_cls   = CLS_LOAD;
            end
            OPC_STORE: begin
                o_imm_sel = IMM_S;
                o_b_src   = 1'b1;
                o_cls     = CLS_STORE;
            end
            OPC_BRANCH: begin
                o_alu_op  = alu_for_branch(i_funct3);
                o_imm_sel = IMM_B;
                o_cls     = CLS_BRANCH;
            end
            OPC_JAL: begin
                o_imm_sel = IMM_J;
                o_a_src   = 1'b1;
                o_b_src   = 1'b1;
                o_cls     = CLS_JAL;
            end
            OPC_JALR: begin
                o_b_src = 1'b1;
                o_cls   = CLS_JALR;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                o_cls = CLS_NOP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control sequencer with retired-instruction counter.
// Define RV_ILLEGAL_TRAP_EN to trap unknown encodings; otherwise they retire as NOPs.
//
//   state  | meaning
//   FETCH  | imem_req high until imem_ready; accept loads IR and PC+4
//   DECODE | decode IR into ALU op / selects (valid from EXEC on)
//   EXEC   | ALU op; branch/jump PC update; branch and NOP retire here
//   MEM    | dmem_req held until dmem_ready; store retires here
//   WB     | register-file write; retire
//   TRAP   | illegal instruction, left only by reset
module rv_mc_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    rv_mc_ctrl_if.master bus
);

    state_t             r_state;
    cls_t               r_cls;
    alu_op_t            r_alu_op;
    imm_sel_t           r_imm_sel;
    logic               r_a_src;
    logic               r_b_src;
    pc_src_t            r_pc_src;
    logic               r_pc_we_ex;
    logic               r_br_ex;
    logic               r_ret_ex;
    logic               r_imem_req;
    logic               r_dmem_req;
    logic               r_dmem_we;
    logic [1:0]         r_dmem_size;
    logic               r_rf_we;
    wb_src_t            r_wb_src;
    logic [CNT_W-1:0]   r_instret;
`ifdef RV_ILLEGAL_TRAP_EN
    logic               r_illegal;
`endif

    alu_op_t            w_alu_op;
    imm_sel_t           w_imm_sel;
    logic               w_a_src;
    logic               w_b_src;
    cls_t               w_cls;
    logic               w_fetch_acc;
    logic               w_retire;
    logic               w_unused;

    rv_alu_dec u_dec (
        .i_opcode   (bus.instr[6:0]),
        .i_funct3   (bus.instr[14:12]),
        .i_funct7_5 (bus.instr[30]),
        .o_alu_op   (w_alu_op),
        .o_imm_sel  (w_imm_sel),
        .o_a_src    (w_a_src),
        .o_b_src    (w_b_src),
        .o_cls      (w_cls)
    );

    assign w_unused = ^{bus.instr[31], bus.instr[29:15]};

    // Ready-qualified strobes act in the same cycle the handshake completes.
    assign w_fetch_acc = r_imem_req & bus.imem_ready;
    assign w_retire    = (r_state == ST_WB) | r_ret_ex
                       | ((r_state == ST_MEM) & (r_cls == CLS_STORE) & bus.dmem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_cls       <= CLS_NOP;
            r_alu_op    <= ALU_ADD;
            r_imm_sel   <= IMM_I;
            r_a_src     <= 1'b0;
            r_b_src     <= 1'b0;
            r_pc_src    <= PC_PLUS4;
            r_pc_we_ex  <= 1'b0;
            r_br_ex     <= 1'b0;
            r_ret_ex    <= 1'b0;
            r_imem_req  <= 1'b0;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_dmem_size <= 2'd0;
            r_rf_we     <= 1'b0;
            r_wb_src    <= WB_ALU;
            r_instret   <= '0;
`ifdef RV_ILLEGAL_TRAP_EN
            r_illegal   <= 1'b0;
`endif
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (r_state)
                ST_FETCH: begin
                    // First cycle out of reset has no request yet; raise it here.
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (bus.imem_ready) begin
                        r_imem_req <= 1'b0;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_cls     <= w_cls;
                    r_alu_op  <= w_alu_op;
                    r_imm_sel <= w_imm_sel;
                    r_a_src   <= w_a_src;
                    r_b_src   <= w_b_src;
                    r_state   <= ST_EXEC;
                    case (w_cls)
                        CLS_BRANCH: begin
                            r_br_ex  <= 1'b1;
                            r_pc_src <= PC_REL;
                            r_ret_ex <= 1'b1;
                        end
                        CLS_JAL: begin
                            r_pc_we_ex <= 1'b1;
                            r_pc_src   <= PC_REL;
                        end
                        CLS_JALR: begin
                            r_pc_we_ex <= 1'b1;
                            r_pc_src   <= PC_JALR;
                        end
                        CLS_NOP: begin
                            r_ret_ex <= 1'b1;
                        end
                        CLS_ILL: begin
`ifdef RV_ILLEGAL_TRAP_EN
                            r_state   <= ST_TRAP;
                            r_illegal <= 1'b1;
                            r_alu_op  <= ALU_ADD;
                            r_imm_sel <= IMM_I;
                            r_a_src   <= 1'b0;
                            r_b_src   <= 1'b0;
`else
                            r_ret_ex  <= 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                ST_EXEC: begin
                    r_br_ex    <= 1'b0;
                    r_pc_we_ex <= 1'b0;
                    r_pc_src   <= PC_PLUS4;
                    r_ret_ex   <= 1'b0;
                    case (r_cls)
                        CLS_LOAD, CLS_STORE: begin
                            r_state     <= ST_MEM;
                            r_dmem_req  <= 1'b1;
                            r_dmem_we   <= (r_cls == CLS_STORE);
                            r_dmem_size <= bus.instr[13:12];
                        end
                        CLS_BRANCH, CLS_NOP, CLS_ILL: begin
                            r_state    <= ST_FETCH;
                            r_imem_req <= 1'b1;
                        end
                        default: begin
                            r_state  <= ST_WB;
                            r_rf_we  <= (bus.instr[11:7] != 5'd0);
                            r_wb_src <= ((r_cls == CLS_JAL) || (r_cls == CLS_JALR)) ? WB_PC4 : WB_ALU;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (bus.dmem_ready) begin
                        r_dmem_req  <= 1'b0;
                        r_dmem_we   <= 1'b0;
                        r_dmem_size <= 2'd0;
                        if (r_cls == CLS_STORE) begin
                            r_state    <= ST_FETCH;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state  <= ST_WB;
                            r_rf_we  <= (bus.instr[11:7] != 5'd0);
                            r_wb_src <= WB_LOAD;
                        end
                    end
                end
                ST_WB: begin
                    r_rf_we    <= 1'b0;
                    r_wb_src   <= WB_ALU;
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.ir_we     = w_fetch_acc;
    assign bus.pc_we     = w_fetch_acc | r_pc_we_ex | (r_br_ex & bus.br_taken);
    assign bus.pc_src    = r_pc_src;
    assign bus.alu_op    = r_alu_op;
    assign bus.alu_a_src = r_a_src;
    assign bus.alu_b_src = r_b_src;
    assign bus.imm_sel   = r_imm_sel;
    assign bus.dmem_req  = r_dmem_req;
    assign bus.dmem_we   = r_dmem_we;
    assign bus.dmem_size = r_dmem_size;
    assign bus.rf_we     = r_rf_we;
    assign bus.wb_src    = r_wb_src;
    assign bus.retire    = w_retire;
    assign bus.instret   = r_instret;
`ifdef RV_ILLEGAL_TRAP_EN
    assign bus.illegal   = r_illegal;
`else
    assign bus.illegal   = 1'b0;
`endif

endmodule
